// File: rtl/sata_rx_dword_aligner.sv
// -----------------------------------------------------------------------------
// sata_rx_dword_aligner
//
// Receive-path stage directly behind the SATA transceiver wrapper. The raw
// 32-bit stream may carry the K28.5 comma in any byte lane; this block picks
// the lane the comma sits in, realigns the stream so that every primitive
// starts in byte lane 0, flags ALIGN primitives and tracks dword sync with a
// LOST / CHECK / LOCKED state machine.
//
// Parameters
//   LOCK_COUNT  aligned ALIGNs needed in CHECK to enter LOCKED      (1..15)
//   ERR_LIMIT   consecutive invalid aligned dwords in LOCKED -> LOST (1..15)
//
// Ports
//   clk           in   1   receive clock (transceiver rx_clock domain)
//   reset         in   1   synchronous, active-high
//   rx_data       in   32  raw dword, byte lane j = rx_data[8j+7:8j]
//   rx_datak      in   4   per-lane K flag
//   out_data      out  32  aligned dword, K28.x byte in [7:0]
//   out_datak     out  4   aligned K flags
//   out_valid     out  1   out_data is a non-ALIGN dword and the FSM is LOCKED
//   out_align     out  1   one-cycle pulse: aligned dword is an ALIGN primitive
//   locked        out  1   FSM in LOCKED
//   lane_offset   out  2   byte lane currently used as dword start
//   lock_loss_cnt out  16  LOCKED->LOST transitions, saturating
//                          (present only when SATA_RX_ALIGN_STAT_EN is defined)
//
// Optional feature macro: SATA_RX_ALIGN_STAT_EN (adds lock_loss_cnt).
//
// Handshake: the output side is valid-only, there is no ready. out_valid is
// asserted for exactly one clk per delivered dword and the consumer must take
// it in that cycle. out_data/out_datak/out_align are updated every cycle
// regardless of out_valid so the link layer can observe the raw aligned flow.
//
// Latency: rx_data -> out_data is 2 clk (one window register, one output
// register).
// -----------------------------------------------------------------------------
module sata_rx_dword_aligner #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned ERR_LIMIT  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rx_data,
    input  logic [3:0]  rx_datak,
    output logic [31:0] out_data,
    output logic [3:0]  out_datak,
    output logic        out_valid,
    output logic        out_align,
    output logic        locked,
    output logic [1:0]  lane_offset
`ifdef SATA_RX_ALIGN_STAT_EN
    ,
    output logic [15:0] lock_loss_cnt
`endif
);

    localparam logic [31:0] ALIGN_DATA = 32'h7B4A4ABC;
    localparam logic [3:0]  ALIGN_K    = 4'b0001;
    localparam logic [7:0]  K28_5      = 8'hBC;
    localparam logic [7:0]  K28_3      = 8'h7C;
    localparam logic [3:0]  LOCK_LIM   = 4'(LOCK_COUNT);
    localparam logic [3:0]  ERR_LIM    = 4'(ERR_LIMIT);

    // Sync state. Kept as a named enum register so checkers can bind to it.
    typedef enum logic [1:0] {
        ST_LOST   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t      state;

    // Previous raw word: lower half of the 64-bit realignment window.
    logic [31:0] prev_data;
    logic [3:0]  prev_k;

    // Byte lane used as dword start.
    logic [1:0]  off;

    logic [3:0]  align_cnt;
    logic [3:0]  err_cnt;

    // Combinational helpers.
    logic [31:0] aligned_data;
    logic [3:0]  aligned_k;
    logic [3:0]  comma_hit;
    logic        comma_any;
    logic [1:0]  comma_lane;
    logic        is_align;
    logic        is_invalid;
    logic [3:0]  align_inc;
    logic [3:0]  err_inc;
    logic        reload;
    logic        gain_lock;
    logic        lose_sync;
    logic        next_locked;

    assign lane_offset = off;

    // -------------------------------------------------------------------------
    // Realignment window: win = {rx, prev}, aligned word = win[8*off +: 32].
    // Written out per offset so each case is an explicit byte splice.
    // -------------------------------------------------------------------------
    always_comb begin
        aligned_data = prev_data;
        aligned_k    = prev_k;
        case (off)
            2'd0: begin
                aligned_data = prev_data;
                aligned_k    = prev_k;
            end
            2'd1: begin
                aligned_data = {rx_data[7:0], prev_data[31:8]};
                aligned_k    = {rx_datak[0], prev_k[3:1]};
            end
            2'd2: begin
                aligned_data = {rx_data[15:0], prev_data[31:16]};
                aligned_k    = {rx_datak[1:0], prev_k[3:2]};
            end
            default: begin
                aligned_data = {rx_data[23:0], prev_data[31:24]};
                aligned_k    = {rx_datak[2:0], prev_k[3]};
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Comma detect on the raw (unaligned) word. Lowest lane wins so that a
    // word carrying two commas resolves deterministically.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            comma_hit[j] = rx_datak[j] && (rx_data[8*j +: 8] == K28_5);
        end
        comma_any  = |comma_hit;
        comma_lane = 2'd0;
        if (comma_hit[0]) begin
            comma_lane = 2'd0;
        end else if (comma_hit[1]) begin
            comma_lane = 2'd1;
        end else if (comma_hit[2]) begin
            comma_lane = 2'd2;
        end else if (comma_hit[3]) begin
            comma_lane = 2'd3;
        end
    end

    // -------------------------------------------------------------------------
    // Classification of the aligned dword and FSM decision terms.
    // -------------------------------------------------------------------------
    always_comb begin
        is_align = (aligned_data == ALIGN_DATA) && (aligned_k == ALIGN_K);

        // A K flag outside lane 0, or a lane-0 K byte that is neither K28.5
        // nor K28.3, cannot start a legal primitive.
        is_invalid = (aligned_k[3:1] != 3'b000) ||
                     (aligned_k[0] && (aligned_data[7:0] != K28_5) &&
                                      (aligned_data[7:0] != K28_3));

        // Saturating increments.
        align_inc = (align_cnt >= LOCK_LIM) ? align_cnt : align_cnt + 4'd1;
        err_inc   = (err_cnt   >= ERR_LIM)  ? err_cnt   : err_cnt   + 4'd1;

        // In CHECK a comma in a different lane means the current offset is
        // wrong; this takes priority over counting the aligned dword, which
        // was still built with the old offset.
        reload    = (state == ST_CHECK) && comma_any && (comma_lane != off);
        gain_lock = (state == ST_CHECK) && !reload && is_align &&
                    (align_inc >= LOCK_LIM);
        // Reaching the error limit always wins over anything else in LOCKED.
        lose_sync = (state == ST_LOCKED) && is_invalid && (err_inc >= ERR_LIM);

        next_locked = ((state == ST_LOCKED) && !lose_sync) || gain_lock;
    end

    // -------------------------------------------------------------------------
    // FSM, window register and registered outputs.
    // locked and out_valid are both driven from next_locked so that they
    // fall on the same edge when sync is lost.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_LOST;
            prev_data <= 32'd0;
            prev_k    <= 4'd0;
            off       <= 2'd0;
            align_cnt <= 4'd0;
            err_cnt   <= 4'd0;
            out_data  <= 32'd0;
            out_datak <= 4'd0;
            out_valid <= 1'b0;
            out_align <= 1'b0;
            locked    <= 1'b0;
        end else begin
            prev_data <= rx_data;
            prev_k    <= rx_datak;

            out_data  <= aligned_data;
            out_datak <= aligned_k;
            out_align <= is_align;
            out_valid <= next_locked && !is_align;
            locked    <= next_locked;

            case (state)
                ST_LOST: begin
                    if (comma_any) begin
                        off       <= comma_lane;
                        align_cnt <= 4'd0;
                        state     <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (reload) begin
                        off       <= comma_lane;
                        align_cnt <= 4'd0;
                    end else if (is_align) begin
                        align_cnt <= align_inc;
                        if (gain_lock) begin
                            err_cnt <= 4'd0;
                            state   <= ST_LOCKED;
                        end
                    end
                    // Non-ALIGN dwords leave the count untouched.
                end

                ST_LOCKED: begin
                    // off is frozen while locked.
                    if (is_invalid) begin
                        if (lose_sync) begin
                            err_cnt   <= 4'd0;
                            align_cnt <= 4'd0;
                            state     <= ST_LOST;
                        end else begin
                            err_cnt <= err_inc;
                        end
                    end else begin
                        err_cnt <= 4'd0;
                    end
                end

                default: begin
                    state <= ST_LOST;
                end
            endcase
        end
    end

`ifdef SATA_RX_ALIGN_STAT_EN
    // Count of sync losses, saturating, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_loss_cnt <= 16'd0;
        end else if (lose_sync && (lock_loss_cnt != 16'hFFFF)) begin
            lock_loss_cnt <= lock_loss_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sata_rx_dword_aligner.sv
// -----------------------------------------------------------------------------
// tb_sata_rx_dword_aligner
//
// Bench for sata_rx_dword_aligner. Every cycle the driven raw word is fed to a
// byte-level reference model; its predicted outputs go to an expected queue
// and are compared against the DUT one clock later. Scenario tasks add
// directed checks for reset, lane 0 lock, lane 2 offset, offset change in
// CHECK, loss of sync, mid-stream reset and a randomized byte stream.
// -----------------------------------------------------------------------------
module tb_sata_rx_dword_aligner;

    localparam int          LOCK_COUNT = 4;
    localparam int          ERR_LIMIT  = 4;
    localparam logic [31:0] ALIGN_W    = 32'h7B4A4ABC;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rx_data;
    logic [3:0]  rx_datak;
    logic [31:0] out_data;
    logic [3:0]  out_datak;
    logic        out_valid;
    logic        out_align;
    logic        locked;
    logic [1:0]  lane_offset;
`ifdef SATA_RX_ALIGN_STAT_EN
    logic [15:0] lock_loss_cnt;
`endif

    always #5 clk = ~clk;

    sata_rx_dword_aligner #(
        .LOCK_COUNT (LOCK_COUNT),
        .ERR_LIMIT  (ERR_LIMIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_datak    (rx_datak),
        .out_data    (out_data),
        .out_datak   (out_datak),
        .out_valid   (out_valid),
        .out_align   (out_align),
        .locked      (locked),
        .lane_offset (lane_offset)
`ifdef SATA_RX_ALIGN_STAT_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Expected output vector: {out_data, out_datak, out_valid, out_align, locked, lane_offset}
    logic [40:0] exp_q[$];

    // ---------------- reference model ----------------
    logic [31:0] m_prev_d;
    logic [3:0]  m_prev_k;
    int          m_mode;     // 0 = lost, 1 = checking, 2 = locked
    int          m_off;
    int          m_acnt;
    int          m_ecnt;
    int          m_losses;

    task automatic model_reset;
        m_prev_d = 32'd0;
        m_prev_k = 4'd0;
        m_mode   = 0;
        m_off    = 0;
        m_acnt   = 0;
        m_ecnt   = 0;
        m_losses = 0;
        exp_q.delete();
    endtask

    // Treat the previous and current raw words as an 8-byte array and take
    // four bytes starting at the chosen offset.
    task automatic model_step(input logic [31:0] d, input logic [3:0] k,
                              output logic [40:0] e);
        logic [7:0]  b[8];
        logic        kb[8];
        logic [31:0] ad;
        logic [3:0]  ak;
        logic        is_al;
        logic        bad;
        int          c;
        for (int i = 0; i < 4; i++) begin
            b[i]      = m_prev_d[8*i +: 8];
            kb[i]     = m_prev_k[i];
            b[i + 4]  = d[8*i +: 8];
            kb[i + 4] = k[i];
        end
        for (int i = 0; i < 4; i++) begin
            ad[8*i +: 8] = b[m_off + i];
            ak[i]        = kb[m_off + i];
        end
        is_al = (ad == ALIGN_W) && (ak == 4'b0001);
        bad   = (ak[3:1] != 3'b000) ||
                (ak[0] && (ad[7:0] != 8'hBC) && (ad[7:0] != 8'h7C));
        c = -1;
        for (int j = 3; j >= 0; j--) begin
            if (k[j] && (d[8*j +: 8] == 8'hBC)) c = j;
        end
        case (m_mode)
            0: begin
                if (c >= 0) begin
                    m_mode = 1;
                    m_off  = c;
                    m_acnt = 0;
                end
            end
            1: begin
                if ((c >= 0) && (c != m_off)) begin
                    m_off  = c;
                    m_acnt = 0;
                end else if (is_al) begin
                    m_acnt = m_acnt + 1;
                    if (m_acnt >= LOCK_COUNT) begin
                        m_mode = 2;
                        m_ecnt = 0;
                    end
                end
            end
            default: begin
                if (bad) begin
                    m_ecnt = m_ecnt + 1;
                    if (m_ecnt >= ERR_LIMIT) begin
                        m_mode   = 0;
                        m_ecnt   = 0;
                        m_losses = m_losses + 1;
                    end
                end else begin
                    m_ecnt = 0;
                end
            end
        endcase
        e = {ad, ak, (m_mode == 2) && !is_al, is_al, m_mode == 2, 2'(m_off)};
        m_prev_d = d;
        m_prev_k = k;
    endtask

    // ---------------- driver + scoreboard ----------------
    task automatic drive(input logic [31:0] d, input logic [3:0] k);
        logic [40:0] e;
        logic [40:0] got;
        @(negedge clk);
        reset    = 1'b0;
        rx_data  = d;
        rx_datak = k;
        model_step(d, k, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = {out_data, out_datak, out_valid, out_align, locked, lane_offset};
        e   = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL scoreboard t=%0t got=%h exp=%h", $time, got, e);
        end
    endtask

    task automatic apply_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            reset    = 1'b1;
            rx_data  = $urandom;
            rx_datak = 4'($urandom);
            @(posedge clk);
            #1;
            n_cmp++;
            if ({out_data, out_datak, out_valid, out_align, locked, lane_offset} !== 41'd0) begin
                n_err++;
                $display("FAIL reset_outputs: data=%h k=%b v=%b a=%b lk=%b off=%0d, required all 0",
                         out_data, out_datak, out_valid, out_align, locked, lane_offset);
            end
`ifdef SATA_RX_ALIGN_STAT_EN
            n_cmp++;
            if (lock_loss_cnt !== 16'd0) begin
                n_err++;
                $display("FAIL reset_stat: lock_loss_cnt=%0d, required 0", lock_loss_cnt);
            end
`endif
        end
        model_reset();
    endtask

    task automatic stim_lock_lane0;
        for (int i = 0; i < LOCK_COUNT; i++) drive(ALIGN_W, 4'b0001);
        drive(32'h12345678, 4'b0000);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        apply_reset(3);
    endtask

    task automatic test_lane0_lock;
        apply_reset(1);
        for (int i = 0; i < 4; i++) drive(ALIGN_W, 4'b0001);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_err++;
            $display("FAIL lane0_early: locked=%b, required 0", locked);
        end
        drive(32'h12345678, 4'b0000);
        n_cmp++;
        if ({locked, out_align, out_valid, out_data} !== {3'b110, ALIGN_W}) begin
            n_err++;
            $display("FAIL lane0_lock: lk=%b a=%b v=%b data=%h, required 1 1 0 %h",
                     locked, out_align, out_valid, out_data, ALIGN_W);
        end
        drive($urandom, 4'b0000);
        n_cmp++;
        if ({out_data, out_valid, out_align} !== {32'h12345678, 2'b10}) begin
            n_err++;
            $display("FAIL lane0_data: data=%h v=%b a=%b, required 12345678 1 0",
                     out_data, out_valid, out_align);
        end
    endtask

    task automatic test_lane2_offset;
        apply_reset(1);
        drive({16'h4ABC, 16'($urandom)}, 4'b0100);
        n_cmp++;
        if (lane_offset !== 2'd2) begin
            n_err++;
            $display("FAIL lane2_offset: lane_offset=%0d, required 2", lane_offset);
        end
        for (int i = 0; i < LOCK_COUNT - 1; i++) drive(32'h4ABC7B4A, 4'b0100);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_err++;
            $display("FAIL lane2_early: locked=%b, required 0", locked);
        end
        drive(32'h4ABC7B4A, 4'b0100);
        n_cmp++;
        if ({locked, out_data, out_datak, lane_offset} !== {1'b1, ALIGN_W, 4'b0001, 2'd2}) begin
            n_err++;
            $display("FAIL lane2_lock: lk=%b data=%h k=%b off=%0d, required 1 %h 0001 2",
                     locked, out_data, out_datak, lane_offset, ALIGN_W);
        end
        drive({16'($urandom), 16'h7B4A}, 4'b0000);
        drive($urandom, 4'b0000);
    endtask

    task automatic test_offset_change;
        apply_reset(1);
        drive(ALIGN_W, 4'b0001);
        drive(ALIGN_W, 4'b0001);
        drive({24'h4A4ABC, 8'($urandom)}, 4'b0010);
        n_cmp++;
        if ({lane_offset, locked} !== {2'd1, 1'b0}) begin
            n_err++;
            $display("FAIL offchg_reload: off=%0d lk=%b, required 1 0", lane_offset, locked);
        end
        for (int i = 0; i < 3; i++) begin
            drive(32'h4A4ABC7B, 4'b0010);
            n_cmp++;
            if (locked !== 1'b0) begin
                n_err++;
                $display("FAIL offchg_early%0d: locked=%b, required 0", i, locked);
            end
        end
        drive(32'h4A4ABC7B, 4'b0010);
        n_cmp++;
        if ({locked, out_data, out_datak} !== {1'b1, ALIGN_W, 4'b0001}) begin
            n_err++;
            $display("FAIL offchg_lock: lk=%b data=%h k=%b, required 1 %h 0001",
                     locked, out_data, out_datak, ALIGN_W);
        end
        drive({24'($urandom), 8'h7B}, 4'b0000);
    endtask

    task automatic test_loss_of_sync;
        apply_reset(1);
        stim_lock_lane0();
        // Three bad then good: must stay locked.
        for (int i = 0; i < ERR_LIMIT - 1; i++) drive($urandom, 4'b0010);
        drive(32'hCAFE0001, 4'b0000);
        n_cmp++;
        if ({locked, out_valid, out_datak} !== {2'b11, 4'b0010}) begin
            n_err++;
            $display("FAIL loss_3bad: lk=%b v=%b k=%b, required 1 1 0010",
                     locked, out_valid, out_datak);
        end
        drive(32'hCAFE0002, 4'b0000);
        n_cmp++;
        if ({locked, out_valid, out_data} !== {2'b11, 32'hCAFE0001}) begin
            n_err++;
            $display("FAIL loss_recover: lk=%b v=%b data=%h, required 1 1 cafe0001",
                     locked, out_valid, out_data);
        end
        // Four bad: lost on the fourth.
        for (int i = 0; i < ERR_LIMIT; i++) drive($urandom, 4'b0010);
        n_cmp++;
        if ({locked, out_valid} !== 2'b11) begin
            n_err++;
            $display("FAIL loss_before: lk=%b v=%b, required 1 1", locked, out_valid);
        end
        drive(32'h00000000, 4'b0000);
        n_cmp++;
        if ({locked, out_valid, out_datak} !== {2'b00, 4'b0010}) begin
            n_err++;
            $display("FAIL loss_4bad: lk=%b v=%b k=%b, required 0 0 0010",
                     locked, out_valid, out_datak);
        end
`ifdef SATA_RX_ALIGN_STAT_EN
        // Re-lock and lose once more.
        stim_lock_lane0();
        for (int i = 0; i < ERR_LIMIT; i++) drive($urandom, 4'b1000);
        drive(32'h00000000, 4'b0000);
        n_cmp++;
        if (lock_loss_cnt !== 16'(m_losses) || m_losses != 2) begin
            n_err++;
            $display("FAIL stat_count: lock_loss_cnt=%0d, required 2", lock_loss_cnt);
        end
`endif
    endtask

    task automatic test_midstream_reset;
        apply_reset(1);
        stim_lock_lane0();
        n_cmp++;
        if (locked !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_pre: locked=%b, required 1", locked);
        end
        apply_reset(1);
        drive($urandom, 4'b0000);
        drive($urandom, 4'b0000);
    endtask

    task automatic test_random;
        logic [7:0]  bq[$];
        logic        kq[$];
        logic [31:0] w;
        logic [3:0]  wk;
        int          r;
        int          lane;
        apply_reset(1);
        repeat ($urandom_range(3, 0)) begin
            bq.push_back(8'($urandom));
            kq.push_back(1'b0);
        end
        for (int p = 0; p < 400; p++) begin
            r = $urandom_range(99, 0);
            if (r < 45) begin
                bq.push_back(8'hBC); kq.push_back(1'b1);
                bq.push_back(8'h4A); kq.push_back(1'b0);
                bq.push_back(8'h4A); kq.push_back(1'b0);
                bq.push_back(8'h7B); kq.push_back(1'b0);
            end else if (r < 78) begin
                for (int i = 0; i < 4; i++) begin
                    bq.push_back(8'($urandom));
                    kq.push_back(1'b0);
                end
            end else if (r < 94) begin
                lane = $urandom_range(3, 0);
                for (int i = 0; i < 4; i++) begin
                    bq.push_back((i == lane && $urandom_range(3, 0) == 0) ? 8'h7C : 8'($urandom));
                    kq.push_back(i == lane);
                end
            end else begin
                repeat ($urandom_range(3, 1)) begin
                    bq.push_back(8'($urandom));
                    kq.push_back(1'b0);
                end
            end
            while (bq.size() >= 4) begin
                for (int i = 0; i < 4; i++) begin
                    w[8*i +: 8] = bq.pop_front();
                    wk[i]       = kq.pop_front();
                end
                drive(w, wk);
            end
        end
`ifdef SATA_RX_ALIGN_STAT_EN
        n_cmp++;
        if (lock_loss_cnt !== 16'(m_losses)) begin
            n_err++;
            $display("FAIL stat_random: lock_loss_cnt=%0d, required %0d", lock_loss_cnt, m_losses);
        end
`endif
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset    = 1'b1;
        rx_data  = 32'd0;
        rx_datak = 4'd0;
        model_reset();
        test_reset();
        test_lane0_lock();
        test_lane2_offset();
        test_offset_change();
        test_loss_of_sync();
        test_midstream_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
